display_arbiter: RTL
====================

Name: display_arbiter

Overview:
Shares the 8-digit seven-segment display datapath between two requesters, A and B. Typical pairing: A is the register/ALU readout, B is the memory address/data monitor. Grants exclusive ownership with a request/grant handshake and round-robin fairness. Enforces a minimum on-screen hold time before preemption, then drives the registered 32-bit nibble word into the display controller's dig7..dig0 inputs (dig7 = bits [31:28]).

Parameters:
HOLD_CYCLES, 100000000, minimum cycles an owner keeps the display before the other requester may preempt; legal range ≥1. Default is 1 s at 100 MHz.
CW, 27, hold counter width; must satisfy 2^CW > HOLD_CYCLES-1.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_a  in  1  requester A wants the display
data_a  in  32  requester A digit word, 8 hex nibbles
req_b  in  1  requester B wants the display
data_b  in  32  requester B digit word
gnt_a  out  1  A owns the display
gnt_b  out  1  B owns the display
disp_data  out  32  word to display controller, registered
disp_blank  out  1  high when no owner; the display controller blanks the anodes
owner  out  2  00 none, 01 A, 10 B, 11 never driven

Behaviour:
- Reset: applied on a clk edge while rst=1.
  - State IDLE; gnt_a=gnt_b=0; disp_data=32'h0; disp_blank=1; owner=00; hold counter=0; last_owner=B, so A wins the first tie.
  - Reset mid-grant drops the grant at that edge, with no completion.
- States:
  - IDLE: owner 00.
  - OWN_A: owner 01, gnt_a=1.
  - OWN_B: owner 10, gnt_b=1.
  - gnt_a and gnt_b are never both 1.
  - All outputs are registered, decoded from state/data registers.
- IDLE transitions, evaluated on the sampled req at edge N; the grant is visible after edge N:
  - Only req_a set: go to OWN_A.
  - Only req_b set: go to OWN_B.
  - Both set: grant the requester that is not last_owner.
  - Neither set: stay in IDLE.
- Entering OWN_x: load the hold counter with HOLD_CYCLES-1 and set last_owner=x.
- While in OWN_x:
  - Decrement the counter each cycle until it reaches 0, then saturate at 0.
  - hold_done is (counter==0).
- OWN_x exits, in priority order:
  1. req_x=0: release on this edge, regardless of hold. Go to OWN_y if req_y=1 (counter reloads), otherwise IDLE.
  2. req_x=1 and req_y=1 and hold_done: preempt, going directly to OWN_y with no blank cycle. Counter reloads and last_owner=y.
  3. Otherwise stay.
- A sole requester keeps the display indefinitely.
- Data path:
  - In OWN_A, disp_data<=data_a every cycle (live tracking); in OWN_B, disp_data<=data_b.
  - On the transition edge disp_data takes the new owner's data, so it is coherent with owner and gnt in the same cycle.
  - In IDLE, disp_data holds its last value and disp_blank=1.
  - Latency: req at edge N gives gnt and disp_data at N+1. A data change at edge N appears at N+1.
- HOLD_CYCLES=1: counter loads 0, so preemption is possible on the first cycle after the grant. Under constant contention, ownership alternates every cycle.
- Requesters hold data stable while req is high and they are granted. The arbiter does not check this.

Decomposition:
- Package display_arb_pkg:
  - State encoding localparams ST_IDLE=2'b00, ST_OWN_A=2'b01, ST_OWN_B=2'b10. These match the owner encoding, so owner is driven directly from state.
  - Constants OWNER_NONE, OWNER_A, OWNER_B.
- Sub-module hold_timer (clk, rst, load, load_val[CW-1:0], done): a saturating down-counter.
- The FSM, data register and output decode stay in display_arbiter.

Test Plan:
All scenarios use HOLD_CYCLES=4.
1. Reset: assert rst 2 cycles with req_a=req_b=1, then deassert.
   - During reset: owner=00, disp_blank=1, disp_data=0.
   - First edge after release: owner=01 (A wins the tie), disp_data=data_a=32'h1234_5678.
2. Sole requester: req_b only, data_b=32'hDEAD_BEEF held for 20 cycles.
   - gnt_b is 1 from cycle 1 onward, disp_data=32'hDEADBEEF throughout, no drop after the hold.
   - Change data_b to 32'h0000_0001: visible exactly one cycle later.
3. Preemption: A granted at cycle 1, req_b raised at cycle 2.
   - A is held until hold_done; owner switches 01→10 at edge 5 with no blank cycle.
   - With both still requesting, owner returns to 01 at edge 9, alternating every 4 cycles.
4. Early release: A granted, req_a dropped at cycle 2 with req_b=1.
   - owner=10 on the next edge.
   - With req_b=0 instead: owner=00 and disp_blank=1; disp_data keeps A's last word.
5. Reset mid-grant: rst pulsed while in OWN_B with the counter at 2.
   - Next edge: owner=00, gnt_b=0, disp_data=0, last_owner=B.
   - After release with both requesting: A granted.
6. Random stress: 10k cycles of random req/data.
   - Scoreboard checks: never gnt_a&gnt_b, owner matches gnt, disp_data equals the granted data from the previous cycle.
   - No preemption before 4 owned cycles.

Source files
------------

// File: rtl/display_arb_pkg.sv
// Shared encodings for the two-requester seven-segment display arbiter.
package display_arb_pkg;

  // State values double as the owner code so owner can be driven straight from state.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

endpackage

// File: rtl/hold_timer.sv
// Saturating down-counter that measures the minimum on-screen hold time.
module hold_timer #(
  parameter int unsigned CW = 27
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 8-digit display datapath with a minimum hold before preemption.
module display_arbiter
  import display_arb_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100000000,
  parameter int unsigned CW          = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] data_a,
  input  logic        req_b,
  input  logic [31:0] data_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [31:0] disp_data,
  output logic        disp_blank,
  output logic [1:0]  owner
);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  state_t state;
  state_t state_nx;
  logic   last_b;
  logic   load;
  logic   hold_done;

  hold_timer #(.CW(CW)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (HOLD_LOAD),
    .done     (hold_done)
  );

  // State register; last_b remembers who was granted most recently for tie-breaking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      last_b <= 1'b1;
    end else begin
      state <= state_nx;
      if (load) begin
        last_b <= (state_nx == ST_OWN_B);
      end
    end
  end

  // Next-state: release beats everything, preemption only once the hold has expired.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_a && req_b) begin
          state_nx = last_b ? ST_OWN_A : ST_OWN_B;
        end else if (req_a) begin
          state_nx = ST_OWN_A;
        end else if (req_b) begin
          state_nx = ST_OWN_B;
        end
      end
      ST_OWN_A: begin
        if (!req_a) begin
          state_nx = req_b ? ST_OWN_B : ST_IDLE;
        end else if (req_b && hold_done) begin
          state_nx = ST_OWN_B;
        end
      end
      ST_OWN_B: begin
        if (!req_b) begin
          state_nx = req_a ? ST_OWN_A : ST_IDLE;
        end else if (req_a && hold_done) begin
          state_nx = ST_OWN_A;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    load = (state_nx != state) && (state_nx != ST_IDLE);
  end

  // Data follows the next owner so word, grant and owner change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_data <= 32'h0;
    end else begin
      case (state_nx)
        ST_OWN_A: disp_data <= data_a;
        ST_OWN_B: disp_data <= data_b;
        default:  disp_data <= disp_data;
      endcase
    end
  end

  assign owner      = state;
  assign gnt_a      = (state == ST_OWN_A);
  assign gnt_b      = (state == ST_OWN_B);
  assign disp_blank = (state == ST_IDLE);

endmodule
